// File: rtl/gray_count_ctrl.sv
// Sequencer for a WIDTH-bit binary/Gray counter: one-shot or wrapping count,
// up or down between 0 and a latched limit, with pause and abort.
module gray_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] start_val, end_val;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Endpoints follow the latched direction: up runs 0..lim_q, down runs lim_q..0.
  assign start_val = dir_q ? lim_q : '0;
  assign end_val   = dir_q ? '0 : lim_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = limit;
          dir_d   = dir;
          mode_d  = mode;
          count_d = dir ? limit : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (count_q != end_val) begin
          count_d = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
        end else if (!mode_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          count_d = start_val;
          wrap_d  = 1'b1;
        end
      end
      PAUSE: begin
        // Resume edge only changes state; stepping restarts on the next edge.
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign gray  = to_gray(count_q);
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Scoreboard bench for gray_count_ctrl: per-cycle stimulus and expected
// {count, gray, busy, done, wrap} are queued, then compared cycle by cycle.
module tb_gray_count_ctrl;
  localparam int W = 4;
  typedef logic [3:0]     stim_t;  // {rst, start, stop, pause}
  typedef logic [2*W+2:0] obs_t;   // {count, gray, busy, done, wrap}

  logic         clk = 1'b0;
  logic         rst, start, stop, pause, dir, mode;
  logic [W-1:0] limit, count, gray;
  logic         busy, done, wrap;

  int    n_checks = 0;
  int    n_fail   = 0;
  obs_t  exp_q[$];
  stim_t stim_q[$];
  int    gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .mode(mode), .limit(limit), .count(count), .gray(gray),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference Gray built bit by bit: g[i] = b[i] ^ b[i+1], MSB passes through.
  function automatic logic [W-1:0] g_ref(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic obs_t e(input int c, input logic b, input logic d, input logic w);
    logic [W-1:0] cv;
    cv = c[W-1:0];
    return {cv, g_ref(cv), b, d, w};
  endfunction

  function automatic obs_t eg(input int c, input int g, input logic b, input logic d,
                              input logic w);
    logic [W-1:0] cv, gv;
    cv = c[W-1:0];
    gv = g[W-1:0];
    return {cv, gv, b, d, w};
  endfunction

  task automatic push(input stim_t s, input obs_t o);
    stim_q.push_back(s);
    exp_q.push_back(o);
  endtask

  task automatic test_reset();
    int i = 0;
    push(4'b1000, e(0, 0, 0, 0));
    push(4'b1100, e(0, 0, 0, 0));   // reset beats start
    push(4'b0000, e(0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_reset step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_up_oneshot();
    int i = 0;
    limit = 4'd5; dir = 1'b0; mode = 1'b0;
    push(4'b0100, eg(0, 0, 1, 0, 0));
    for (int c = 1; c <= 5; c++) push(4'b0000, eg(c, gtab[c], 1, 0, 0));
    push(4'b0000, eg(5, 7, 0, 1, 0));
    push(4'b0000, eg(5, 7, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      if (i == 2) limit = 4'd9;     // must not extend the latched run
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_up_oneshot step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_down_oneshot();
    int i = 0;
    limit = 4'd3; dir = 1'b1; mode = 1'b0;
    push(4'b0100, eg(3, 2, 1, 0, 0));
    push(4'b0000, eg(2, 3, 1, 0, 0));
    push(4'b0000, eg(1, 1, 1, 0, 0));
    push(4'b0000, eg(0, 0, 1, 0, 0));
    push(4'b0000, eg(0, 0, 0, 1, 0));
    push(4'b0000, eg(0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_down_oneshot step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_continuous();
    int i = 0;
    limit = 4'd15; dir = 1'b0; mode = 1'b1;
    push(4'b0100, eg(0, 0, 1, 0, 0));
    for (int c = 1; c <= 15; c++) push(4'b0000, eg(c, gtab[c], 1, 0, 0));
    push(4'b0000, eg(0, 0, 1, 0, 1));
    push(4'b0000, eg(1, 1, 1, 0, 0));
    push(4'b0010, eg(1, 1, 0, 0, 0));   // abort: no done pulse
    push(4'b0000, eg(1, 1, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_continuous step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_pause();
    int i = 0;
    limit = 4'd6; dir = 1'b0; mode = 1'b0;
    push(4'b0100, e(0, 1, 0, 0));
    push(4'b0000, e(1, 1, 0, 0));
    push(4'b0000, e(2, 1, 0, 0));
    for (int k = 0; k < 3; k++) push(4'b0001, e(2, 1, 0, 0));
    push(4'b0000, e(2, 1, 0, 0));       // resume edge: no step
    for (int c = 3; c <= 6; c++) push(4'b0000, e(c, 1, 0, 0));
    push(4'b0000, e(6, 0, 1, 0));
    push(4'b0000, e(6, 0, 0, 0));
    push(4'b0100, e(0, 1, 0, 0));
    push(4'b0000, e(1, 1, 0, 0));
    push(4'b0001, e(1, 1, 0, 0));
    push(4'b0011, e(1, 0, 0, 0));       // stop from PAUSE: no done
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_pause step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_start_ignored();
    int i = 0;
    limit = 4'd3; dir = 1'b0; mode = 1'b0;
    push(4'b0100, e(0, 1, 0, 0));
    push(4'b0100, e(1, 1, 0, 0));       // restart attempt with new settings
    push(4'b0000, e(2, 1, 0, 0));
    push(4'b0000, e(3, 1, 0, 0));
    push(4'b0000, e(3, 0, 1, 0));
    push(4'b0000, e(3, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      if (i == 1) begin
        limit = 4'd1; dir = 1'b1; mode = 1'b1;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_start_ignored step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_reset_midrun();
    int i = 0;
    limit = 4'd9; dir = 1'b0; mode = 1'b0;
    push(4'b0100, e(0, 1, 0, 0));
    for (int c = 1; c <= 4; c++) push(4'b0000, e(c, 1, 0, 0));
    push(4'b1000, e(0, 0, 0, 0));
    push(4'b0000, e(0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_reset_midrun step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  task automatic test_limit_zero();
    int i = 0;
    limit = 4'd0; dir = 1'b0; mode = 1'b0;
    push(4'b0100, e(0, 1, 0, 0));
    push(4'b0000, e(0, 0, 1, 0));
    push(4'b0000, e(0, 0, 0, 0));
    push(4'b0110, e(0, 1, 0, 0));       // start with stop in IDLE: start wins
    for (int k = 0; k < 4; k++) push(4'b0000, e(0, 1, 0, 1));
    push(4'b0010, e(0, 0, 0, 0));
    push(4'b0000, e(0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      stim_t s;
      obs_t  x;
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      {rst, start, stop, pause} = s;
      if (i == 3) mode = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({count, gray, busy, done, wrap} !== x) begin
        n_fail++;
        $display("FAIL test_limit_zero step %0d: got %h expected %h", i,
                 {count, gray, busy, done, wrap}, x);
      end
      i++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    dir = 1'b0; mode = 1'b0; limit = '0;
    test_reset();
    test_up_oneshot();
    test_down_oneshot();
    test_continuous();
    test_pause();
    test_start_ignored();
    test_reset_midrun();
    test_limit_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
